u712_local_bus_master: RTL and testbench
========================================

# u712_local_bus_master

Initiator for MC68040 local-bus cycles on CLK40. Internal clients (chiefly the PCI bridge) reach chip RAM and chipset registers through the same nTS/nTA path the CPU uses. The block requests and arbitrates for the bus, drives one single or line transfer, collects nTA/nTBI/nTEA terminations, then hands the bus back to the CPU. It sits alongside the chip-RAM and register-cycle logic in U712, which acts as the responder to its cycles.

## Interface
Parameters:
- TIMEOUT, default 255: CLK40 cycles allowed without nTA/nTEA before a cycle is aborted (8-bit counter).

Ports:
- CLK40  in  1  sole clock, 40 MHz, all logic on rising edge
- nRESET  in  1  reset; one clock; reset is synchronous and active-low
- REQ  in  1  client request; sampled in IDLE only; request fields must stay stable until DONE or ERR
- REQ_RnW  in  1  1 = read, 0 = write
- REQ_LINE  in  1  1 = 16-byte line transfer (SIZ=11); 0 = single transfer
- REQ_SIZ  in  2  SIZ for a single transfer (00 long, 01 byte, 10 word)
- REQ_A  in  32  start address
- REQ_WDATA  in  32  write data for the current beat; advanced by the client on ACK
- ACK  out  1  one-clock pulse per completed beat
- RDATA  out  32  read data, valid when ACK = 1
- DONE  out  1  one-clock pulse when the whole transfer has completed
- ERR  out  1  one-clock pulse when the transfer aborts on nTEA or timeout
- nBR  out  1  bus request
- nBG  in  1  bus grant
- nBB_IN  in  1  bus-busy sense
- nBB_OUT, BB_OE  out  1,1  bus-busy drive and its output enable
- nTS  out  1  transfer start
- A_OUT  out  32  address
- RnW_OUT, SIZ_OUT, TT_OUT  out  1,2,2  cycle attributes; TT_OUT is fixed at 00
- ADDR_OE  out  1  enable for A/RnW/SIZ/TT/nTS
- D_IN  in  32  data bus in
- D_OUT, DATA_OE  out  32,1  write data and its enable
- nTA, nTBI, nTEA  in  1 each  responder terminations; all are active low and sampled on the rising edge

## Operation
- States: IDLE, ARB, OWN, TS, WAIT, REL.
- IDLE: all outputs at reset values. If REQ = 1, go to ARB.
- ARB: nBR = 0. When nBG = 0 and nBB_IN = 1 on the same edge:
  - drive nBB_OUT = 0 and BB_OE = 1; nBR = 1
  - go to OWN.
- OWN: ADDR_OE = 1 and attributes are driven.
  - A_OUT = REQ_A; SIZ_OUT = 11 if REQ_LINE, else REQ_SIZ.
  - DATA_OE = ~REQ_RnW.
  - Go to TS.
- TS: nTS = 0 for exactly one clock, then go to WAIT.
- WAIT: terminations are checked in this priority order.
  - nTEA = 0: ERR pulses and the block goes to REL. nTEA wins over a simultaneous nTA.
  - nTA = 0, single transfer: ACK pulses; RDATA = D_IN on reads; DONE pulses in the same clock; go to REL.
  - nTA = 0, line transfer with nTBI = 1 on the first beat: burst proceeds. ACK pulses on each of 4 beats; a 2-bit beat counter advances A_OUT[3:2] modulo 4 (wrap 11 -> 00). DONE pulses with the 4th ACK; go to REL.
  - nTA = 0 and nTBI = 0 on the first line beat: that beat completes normally. The remaining 3 beats are run as separate longword cycles: SIZ_OUT = 00, A_OUT[3:2] advances modulo 4, each goes through TS again. DONE pulses with the final ACK.
  - Timeout: the counter resets on every nTS and every nTA. When it reaches TIMEOUT, ERR pulses and the block goes to REL.
- REL: one clock with nBB_OUT = 1 and BB_OE = 1, nTS = 1, ADDR_OE = 0, DATA_OE = 0. Next state IDLE, where BB_OE = 0.
- Write data: D_OUT = REQ_WDATA, re-sampled each clock while DATA_OE = 1.

## Timing
- Reset values: nBR = 1, nBB_OUT = 1, BB_OE = 0, nTS = 1, ADDR_OE = 0, DATA_OE = 0, A_OUT = 0, RnW_OUT = 1, SIZ_OUT = 00, TT_OUT = 00, D_OUT = 0, RDATA = 0, ACK = 0, DONE = 0, ERR = 0.
- Minimum single-transfer latency: REQ to nTS low is 3 clocks (IDLE->ARB, ARB->OWN with grant already present, OWN->TS).
- Response: earliest nTA is 1 clock after nTS; ACK and DONE follow 1 clock after nTA is sampled.
- nBG is withdrawn during ARB: the block stays in ARB and nBR stays asserted.
- nBG is withdrawn after OWN: the current transfer completes, since the 68040 bus is not preempted mid-transfer.
- nRESET low in any state: all outputs return to reset values on the next edge, nothing is pulsed on ERR/DONE, state is IDLE.
- REQ held high after DONE: a new arbitration starts from IDLE on the next clock.

## Test plan
- Single long read, nBG = 0 and nBB_IN = 1 held, nTA 2 clocks after nTS, D_IN = 0xDEADBEEF -> nTS low once, SIZ_OUT = 00, one ACK with RDATA = 0xDEADBEEF, DONE coincident, BB_OE = 0 two clocks later.
- Line write at REQ_A = 0x00100008, 4 consecutive nTA -> A_OUT[3:2] sequence 10,11,00,01, four ACKs, D_OUT = REQ_WDATA per beat, DONE with the 4th.
- Line read with nTBI = 0 on the first nTA -> 4 nTS pulses total, SIZ_OUT = 11 then 00, 00, 00, four ACKs, a single DONE.
- nTEA and nTA asserted together on a word write -> ERR = 1, ACK = 0, DONE = 0, bus released through REL.
- No termination with TIMEOUT = 8 -> ERR exactly 8 clocks after nTS, return to IDLE.
- nRESET pulsed low while in WAIT -> all outputs reset on the next edge; a subsequent REQ completes normally.

Source files
------------

// File: rtl/u712_local_bus_master_if.sv
// Client-request and 68040 local-bus signals of the U712 local-bus master.
// The master modport is the initiator's view; slave is the client/responder view.
interface u712_local_bus_master_if;
  logic        REQ;
  logic        REQ_RnW;
  logic        REQ_LINE;
  logic [1:0]  REQ_SIZ;
  logic [31:0] REQ_A;
  logic [31:0] REQ_WDATA;
  logic        ACK;
  logic [31:0] RDATA;
  logic        DONE;
  logic        ERR;
  logic        nBR;
  logic        nBG;
  logic        nBB_IN;
  logic        nBB_OUT;
  logic        BB_OE;
  logic        nTS;
  logic [31:0] A_OUT;
  logic        RnW_OUT;
  logic [1:0]  SIZ_OUT;
  logic [1:0]  TT_OUT;
  logic        ADDR_OE;
  logic [31:0] D_IN;
  logic [31:0] D_OUT;
  logic        DATA_OE;
  logic        nTA;
  logic        nTBI;
  logic        nTEA;

  modport master (
    input  REQ, REQ_RnW, REQ_LINE, REQ_SIZ, REQ_A, REQ_WDATA,
    output ACK, RDATA, DONE, ERR,
    output nBR, input nBG, input nBB_IN, output nBB_OUT, BB_OE,
    output nTS, A_OUT, RnW_OUT, SIZ_OUT, TT_OUT, ADDR_OE,
    input  D_IN, output D_OUT, DATA_OE,
    input  nTA, nTBI, nTEA
  );

  modport slave (
    output REQ, REQ_RnW, REQ_LINE, REQ_SIZ, REQ_A, REQ_WDATA,
    input  ACK, RDATA, DONE, ERR,
    input  nBR, output nBG, output nBB_IN, input nBB_OUT, BB_OE,
    input  nTS, A_OUT, RnW_OUT, SIZ_OUT, TT_OUT, ADDR_OE,
    output D_IN, input D_OUT, DATA_OE,
    output nTA, nTBI, nTEA
  );
endinterface

// File: rtl/u712_local_bus_master.sv
// 68040 local-bus initiator: arbitrates, runs one single/line cycle, releases the bus through REL.
// REQ to nTS >= 3 clocks; ACK/DONE/ERR registered one clock after a termination; client waits on ACK.
module u712_local_bus_master #(
  parameter int TIMEOUT = 255
) (
  input  logic                    CLK40,
  input  logic                    nRESET,
  u712_local_bus_master_if.master bus
);

  typedef enum logic [2:0] {ST_IDLE, ST_ARB, ST_OWN, ST_TS, ST_WAIT, ST_REL} state_t;

  state_t      state, state_nxt;
  logic [1:0]  beat;
  logic        split;
  logic [7:0]  tmo_cnt;
  logic        ack_q, done_q, err_q;
  logic [31:0] rdata_q, dout_q;

  logic        owned, data_oe;
  logic        ta_hit, tea_hit, tmo_hit, first_split, last_beat;
  logic [1:0]  a_word;

  assign owned       = (state == ST_OWN) || (state == ST_TS) || (state == ST_WAIT);
  assign data_oe     = owned && !bus.REQ_RnW;
  assign a_word      = bus.REQ_A[3:2] + beat;
  assign tea_hit     = (state == ST_WAIT) && !bus.nTEA;
  assign ta_hit      = (state == ST_WAIT) && bus.nTEA && !bus.nTA;
  assign tmo_hit     = (state == ST_WAIT) && bus.nTEA && bus.nTA && (tmo_cnt == 8'(TIMEOUT - 1));
  // A burst-inhibited line becomes three extra longword cycles, each restarting at TS.
  assign first_split = bus.REQ_LINE && (beat == 2'd0) && !bus.nTBI;
  assign last_beat   = !bus.REQ_LINE || (beat == 2'd3);

  always_ff @(posedge CLK40) begin
    if (!nRESET) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.REQ) state_nxt = ST_ARB;
      ST_ARB:  if (!bus.nBG && bus.nBB_IN) state_nxt = ST_OWN;
      ST_OWN:  state_nxt = ST_TS;
      ST_TS:   state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (tea_hit || tmo_hit || (ta_hit && last_beat)) state_nxt = ST_REL;
        else if (ta_hit && (split || first_split))       state_nxt = ST_TS;
      end
      ST_REL:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK40) begin
    if (!nRESET) begin
      beat    <= 2'd0;
      split   <= 1'b0;
      tmo_cnt <= 8'd0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      dout_q  <= '0;
    end else begin
      ack_q   <= ta_hit;
      done_q  <= ta_hit && last_beat;
      err_q   <= tea_hit || tmo_hit;
      rdata_q <= (ta_hit && bus.REQ_RnW) ? bus.D_IN : '0;
      dout_q  <= data_oe ? bus.REQ_WDATA : '0;
      if (state == ST_IDLE) begin
        beat  <= 2'd0;
        split <= 1'b0;
      end else if (ta_hit) begin
        beat <= beat + 2'd1;
        if (first_split) split <= 1'b1;
      end
      // tmo_cnt holds clocks elapsed since the last nTS or nTA.
      if ((state == ST_TS) || ta_hit) tmo_cnt <= 8'd1;
      else if (state == ST_WAIT)      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  always_comb begin
    bus.nBR     = (state != ST_ARB);
    bus.nBB_OUT = !owned;
    bus.BB_OE   = owned || (state == ST_REL);
    bus.nTS     = (state != ST_TS);
    bus.ADDR_OE = owned;
    bus.A_OUT   = owned ? {bus.REQ_A[31:4], a_word, bus.REQ_A[1:0]} : '0;
    bus.RnW_OUT = owned ? bus.REQ_RnW : 1'b1;
    bus.SIZ_OUT = 2'b00;
    if (owned) bus.SIZ_OUT = !bus.REQ_LINE ? bus.REQ_SIZ : (split ? 2'b00 : 2'b11);
    bus.TT_OUT  = 2'b00;
    bus.DATA_OE = data_oe;
    bus.D_OUT   = dout_q;
    bus.RDATA   = rdata_q;
    bus.ACK     = ack_q;
    bus.DONE    = done_q;
    bus.ERR     = err_q;
  end

endmodule

// File: tb/tb_u712_local_bus_master.sv
// Bench for u712_local_bus_master: directed transfers, queued expectations, monitor on nTS/ACK/ERR.
module tb_u712_local_bus_master;

  typedef struct {logic [31:0] a; logic [1:0] siz; logic rnw;} ts_t;
  typedef struct {logic rd; logic [31:0] data; logic done;} ack_t;

  logic CLK40 = 1'b0;
  logic nRESET;
  always #5 CLK40 = ~CLK40;

  u712_local_bus_master_if bus();

  u712_local_bus_master #(.TIMEOUT(8)) dut (
    .CLK40  (CLK40),
    .nRESET (nRESET),
    .bus    (bus.master)
  );

  ts_t  exp_ts[$];
  ack_t exp_ack[$];
  int   exp_err[$];

  int          errors = 0;
  int          checks = 0;
  int          n_ts;
  int          cyc = 0;
  int          last_nts = 0;
  logic        mon_en = 1'b0;
  logic        prev_doe = 1'b0;
  logic        prev_rst = 1'b0;
  logic [31:0] prev_wd = '0;
  logic [31:0] wdata_base = 32'h0;
  int unsigned wdata_idx = 0;
  logic [1:0]  seq [4];

  assign bus.REQ_WDATA = wdata_base + wdata_idx;

  localparam logic [127:0] RST_OUTS = 128'({1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1,
                                             2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0});

  function automatic logic [127:0] outs();
    return 128'({bus.nBR, bus.nBB_OUT, bus.BB_OE, bus.nTS, bus.ADDR_OE, bus.DATA_OE, bus.A_OUT,
                 bus.RnW_OUT, bus.SIZ_OUT, bus.TT_OUT, bus.D_OUT, bus.RDATA, bus.ACK, bus.DONE,
                 bus.ERR});
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK40);
    #1;
  endtask

  task automatic await_nts(output int n);
    n = 0;
    while (bus.nTS !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) check("nts_wait", 128'(bus.nTS), 128'(0));
  endtask

  task automatic start(input logic [31:0] a, input logic rnw, input logic line, input logic [1:0] siz);
    bus.REQ_A    = a;
    bus.REQ_RnW  = rnw;
    bus.REQ_LINE = line;
    bus.REQ_SIZ  = siz;
    bus.REQ      = 1'b1;
  endtask

  task automatic term(input int dly, input logic [31:0] d, input logic tbi_n, input logic tea_n,
                      input logic ta_n);
    repeat (dly) tick();
    bus.D_IN = d;
    bus.nTA  = ta_n;
    bus.nTBI = tbi_n;
    bus.nTEA = tea_n;
    tick();
    bus.nTA  = 1'b1;
    bus.nTBI = 1'b1;
    bus.nTEA = 1'b1;
  endtask

  task automatic push_ts(input logic [31:0] a, input logic [1:0] siz, input logic rnw);
    ts_t e;
    e.a = a; e.siz = siz; e.rnw = rnw;
    exp_ts.push_back(e);
  endtask

  task automatic push_ack(input logic rd, input logic [31:0] data, input logic done);
    ack_t e;
    e.rd = rd; e.data = data; e.done = done;
    exp_ack.push_back(e);
  endtask

  task automatic drain(input string name);
    check({name, "_queues_empty"}, 128'(exp_ts.size() + exp_ack.size() + exp_err.size()), 128'(0));
  endtask

  initial begin
    nRESET = 1'b0;
    bus.REQ = 1'b0; bus.REQ_RnW = 1'b1; bus.REQ_LINE = 1'b0; bus.REQ_SIZ = 2'b00;
    bus.REQ_A = '0; bus.nBG = 1'b0; bus.nBB_IN = 1'b1; bus.D_IN = '0;
    bus.nTA = 1'b1; bus.nTBI = 1'b1; bus.nTEA = 1'b1;
    seq[0] = 2'b10; seq[1] = 2'b11; seq[2] = 2'b00; seq[3] = 2'b01;
    fork
      begin : monitor
        ts_t  et;
        ack_t ea;
        int   ed;
        forever begin
          @(negedge CLK40);
          cyc++;
          if (mon_en) begin
            if (prev_doe && prev_rst) check("d_out", 128'(bus.D_OUT), 128'(prev_wd));
            if (bus.nTS === 1'b0) begin
              last_nts = cyc;
              if (exp_ts.size() == 0) check("unexp_nts", 128'(bus.nTS), 128'(1));
              else begin
                et = exp_ts.pop_front();
                check("ts_attr", 128'({bus.A_OUT, bus.SIZ_OUT, bus.RnW_OUT}),
                      128'({et.a, et.siz, et.rnw}));
              end
            end
            if (bus.ACK === 1'b1) begin
              if (exp_ack.size() == 0) check("unexp_ack", 128'(bus.ACK), 128'(0));
              else begin
                ea = exp_ack.pop_front();
                check("ack_done", 128'(bus.DONE), 128'(ea.done));
                if (ea.rd) check("rdata", 128'(bus.RDATA), 128'(ea.data));
              end
            end else if (bus.DONE === 1'b1) check("unexp_done", 128'(bus.DONE), 128'(0));
            if (bus.ERR === 1'b1) begin
              if (exp_err.size() == 0) check("unexp_err", 128'(bus.ERR), 128'(0));
              else begin
                ed = exp_err.pop_front();
                check("err_no_ack_done", 128'({bus.ACK, bus.DONE}), 128'(0));
                if (ed >= 0) check("err_delay", 128'(cyc - last_nts), 128'(ed));
              end
            end
          end
          prev_doe = bus.DATA_OE;
          prev_wd  = bus.REQ_WDATA;
          prev_rst = nRESET;
        end
      end
      begin : client
        forever begin
          @(negedge CLK40);
          if (bus.ACK === 1'b1) begin
            @(posedge CLK40);
            #1;
            wdata_idx++;
          end
        end
      end
      begin : watchdog
        #50000;
        $display("FAIL watchdog: time limit reached with %0d checks", checks);
        $fatal(1, "watchdog");
      end
      begin : stimulus
        repeat (3) tick();
        check("reset_outs", outs(), RST_OUTS);
        nRESET = 1'b1;
        tick();
        mon_en = 1'b1;

        // single long read, nTA two clocks after nTS
        push_ts(32'h0000_1000, 2'b00, 1'b1);
        push_ack(1'b1, 32'hDEAD_BEEF, 1'b1);
        start(32'h0000_1000, 1'b1, 1'b0, 2'b00);
        await_nts(n_ts);
        check("req_to_nts_latency", 128'(n_ts), 128'(3));
        bus.REQ = 1'b0;
        term(2, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0);
        tick();
        check("single_read_idle", outs(), RST_OUTS);
        drain("single_read");

        // line write, four back-to-back beats, address wraps within the line
        wdata_base = 32'hA5A5_0000;
        push_ts(32'h0010_0008, 2'b11, 1'b0);
        push_ack(1'b0, '0, 1'b0); push_ack(1'b0, '0, 1'b0);
        push_ack(1'b0, '0, 1'b0); push_ack(1'b0, '0, 1'b1);
        start(32'h0010_0008, 1'b0, 1'b1, 2'b00);
        await_nts(n_ts);
        bus.REQ = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
          bus.nTA = 1'b0;
          check("line_a32", 128'(bus.A_OUT[3:2]), 128'(seq[i]));
          tick();
        end
        bus.nTA = 1'b1;
        tick();
        check("line_write_idle", outs(), RST_OUTS);
        drain("line_write");

        // line read with nTBI on the first beat: four separate cycles
        push_ts(32'h0020_0004, 2'b11, 1'b1);
        push_ts(32'h0020_0008, 2'b00, 1'b1);
        push_ts(32'h0020_000C, 2'b00, 1'b1);
        push_ts(32'h0020_0000, 2'b00, 1'b1);
        for (int i = 0; i < 4; i++) push_ack(1'b1, 32'h1111_0000 + 32'(i), (i == 3));
        start(32'h0020_0004, 1'b1, 1'b1, 2'b00);
        for (int i = 0; i < 4; i++) begin
          await_nts(n_ts);
          bus.REQ = 1'b0;
          term(1, 32'h1111_0000 + 32'(i), (i == 0) ? 1'b0 : 1'b1, 1'b1, 1'b0);
        end
        tick();
        check("tbi_read_idle", outs(), RST_OUTS);
        drain("tbi_read");

        // nTEA together with nTA on a word write
        push_ts(32'h0030_0002, 2'b10, 1'b0);
        exp_err.push_back(-1);
        start(32'h0030_0002, 1'b0, 1'b0, 2'b10);
        await_nts(n_ts);
        bus.REQ = 1'b0;
        term(1, '0, 1'b1, 1'b0, 1'b0);
        check("tea_rel_bus", 128'({bus.BB_OE, bus.nBB_OUT, bus.ADDR_OE, bus.DATA_OE, bus.nTS}),
              128'(5'b11001));
        tick();
        check("tea_idle", outs(), RST_OUTS);
        drain("tea");

        // no termination: ERR eight clocks after nTS
        push_ts(32'h0040_0000, 2'b00, 1'b1);
        exp_err.push_back(8);
        start(32'h0040_0000, 1'b1, 1'b0, 2'b00);
        await_nts(n_ts);
        bus.REQ = 1'b0;
        repeat (10) tick();
        check("timeout_idle", outs(), RST_OUTS);
        drain("timeout");

        // grant withheld in ARB, withdrawn mid-transfer, REQ held over DONE
        bus.nBG = 1'b1;
        push_ts(32'h0050_0000, 2'b00, 1'b1);
        push_ack(1'b1, 32'hCAFE_F00D, 1'b1);
        start(32'h0050_0000, 1'b1, 1'b0, 2'b00);
        repeat (4) tick();
        check("arb_hold", 128'({bus.nBR, bus.nTS, bus.ADDR_OE}), 128'(3'b010));
        bus.nBG = 1'b0;
        await_nts(n_ts);
        bus.nBG = 1'b1;
        term(1, 32'hCAFE_F00D, 1'b1, 1'b1, 1'b0);
        tick();
        check("idle_between", outs(), RST_OUTS);
        tick();
        check("rearb", 128'({bus.nBR, bus.BB_OE}), 128'(2'b00));
        tick();
        check("rearb_hold", 128'(bus.nBR), 128'(0));
        bus.REQ = 1'b0;
        nRESET = 1'b0;
        tick();
        check("reset_from_arb", outs(), RST_OUTS);
        nRESET = 1'b1;
        bus.nBG = 1'b0;
        tick();
        drain("grant");

        // reset during WAIT, then a clean transfer
        push_ts(32'h0060_0000, 2'b00, 1'b1);
        start(32'h0060_0000, 1'b1, 1'b0, 2'b00);
        await_nts(n_ts);
        bus.REQ = 1'b0;
        tick();
        nRESET = 1'b0;
        tick();
        check("reset_in_wait", outs(), RST_OUTS);
        nRESET = 1'b1;
        tick();
        push_ts(32'h0060_0010, 2'b00, 1'b1);
        push_ack(1'b1, 32'h0BAD_CAFE, 1'b1);
        start(32'h0060_0010, 1'b1, 1'b0, 2'b00);
        await_nts(n_ts);
        bus.REQ = 1'b0;
        term(1, 32'h0BAD_CAFE, 1'b1, 1'b1, 1'b0);
        tick();
        check("after_reset_idle", outs(), RST_OUTS);
        repeat (2) tick();
        drain("after_reset");
      end
    join_any
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
